// File: rtl/cache_refill_ctrl.sv
// Line-refill controller: picks a round-robin victim way per set, fetches a 64 B
// line as 16 sequential 32-bit beats, writes each word, then commits the tag.
module cache_refill_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_sys_i,
   input  logic              rst_n_i,
   input  logic              miss_valid_i,
   input  logic [ADDR_W-1:0] miss_addr_i,
   output logic              miss_ready_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              fill_we_o,
   output logic [7:0]        fill_index_o,
   output logic [1:0]        fill_way_o,
   output logic [3:0]        fill_word_o,
   output logic [DATA_W-1:0] fill_data_o,
   output logic              tag_we_o,
   output logic [ADDR_W-15:0] tag_o,
   output logic              refill_done_o
);

   localparam int TAG_W = ADDR_W - 14;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_REQ    = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_COMMIT = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-7:0] line_q, line_d;
   logic [3:0]        beat_q, beat_d;
   logic [3:0]        beat_nxt;
   logic [7:0]        index_q, index_d;
   logic [1:0]        way_q, way_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              fill_we_q, fill_we_d;
   logic [3:0]        word_q, word_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [255:0][1:0] rr_q;

   // Byte offset within the line never matters: the whole line is fetched.
   logic unused_addr_bits;
   assign unused_addr_bits = ^miss_addr_i[5:0];

   assign beat_nxt = beat_q + 4'd1;

   always_comb begin
      state_d   = state_q;
      line_d    = line_q;
      beat_d    = beat_q;
      index_d   = index_q;
      way_d     = way_q;
      tag_d     = tag_q;
      addr_d    = addr_q;
      fill_we_d = 1'b0;
      word_d    = word_q;
      data_d    = data_q;
      case (state_q)
         S_IDLE: begin
            if (miss_valid_i) begin
               line_d  = miss_addr_i[ADDR_W-1:6];
               index_d = miss_addr_i[13:6];
               tag_d   = miss_addr_i[ADDR_W-1:14];
               way_d   = rr_q[miss_addr_i[13:6]];
               beat_d  = 4'd0;
               addr_d  = {miss_addr_i[ADDR_W-1:6], 6'b0};
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_gnt_i) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rvalid_i) begin
               fill_we_d = 1'b1;
               word_d    = beat_q;
               data_d    = mem_rdata_i;
               if (beat_q == 4'd15) begin
                  state_d = S_COMMIT;
               end else begin
                  // Beat address is built by concatenation, so it cannot carry out of the line.
                  beat_d  = beat_nxt;
                  addr_d  = {line_q, beat_nxt, 2'b00};
                  state_d = S_REQ;
               end
            end
         end
         S_COMMIT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= S_IDLE;
         line_q    <= '0;
         beat_q    <= '0;
         index_q   <= '0;
         way_q     <= '0;
         tag_q     <= '0;
         addr_q    <= '0;
         fill_we_q <= 1'b0;
         word_q    <= '0;
         data_q    <= '0;
         rr_q      <= '0;
      end else begin
         state_q   <= state_d;
         line_q    <= line_d;
         beat_q    <= beat_d;
         index_q   <= index_d;
         way_q     <= way_d;
         tag_q     <= tag_d;
         addr_q    <= addr_d;
         fill_we_q <= fill_we_d;
         word_q    <= word_d;
         data_q    <= data_d;
         if (state_q == S_COMMIT) rr_q[index_q] <= rr_q[index_q] + 2'd1;
      end
   end

   assign miss_ready_o  = (state_q == S_IDLE);
   assign mem_req_o     = (state_q == S_REQ);
   assign mem_addr_o    = addr_q;
   assign fill_we_o     = fill_we_q;
   assign fill_index_o  = index_q;
   assign fill_way_o    = way_q;
   assign fill_word_o   = word_q;
   assign fill_data_o   = data_q;
   assign tag_we_o      = (state_q == S_COMMIT);
   assign tag_o         = tag_q;
   assign refill_done_o = (state_q == S_COMMIT);

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized bench for cache_refill_ctrl: the driver plays lookup stage and RAM,
// pushing expectations from a line-level model; a monitor pops and compares.
module tb_cache_refill_ctrl;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef struct packed {
      logic [7:0]  idx;
      logic [1:0]  way;
      logic [3:0]  word;
      logic [31:0] data;
   } fill_t;

   typedef struct packed {
      logic [17:0] tag;
      logic [7:0]  idx;
      logic [1:0]  way;
   } commit_t;

   logic              clk, rst_n;
   logic              miss_valid, miss_ready;
   logic [ADDR_W-1:0] miss_addr;
   logic              mem_req, mem_gnt, mem_rvalid;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic              fill_we, tag_we, refill_done;
   logic [7:0]        fill_index;
   logic [1:0]        fill_way;
   logic [3:0]        fill_word;
   logic [DATA_W-1:0] fill_data;
   logic [17:0]       tag;

   cache_refill_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk_sys_i(clk), .rst_n_i(rst_n),
      .miss_valid_i(miss_valid), .miss_addr_i(miss_addr), .miss_ready_o(miss_ready),
      .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
      .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
      .fill_we_o(fill_we), .fill_index_o(fill_index), .fill_way_o(fill_way),
      .fill_word_o(fill_word), .fill_data_o(fill_data),
      .tag_we_o(tag_we), .tag_o(tag), .refill_done_o(refill_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   fill_t             fq[$];
   commit_t           cq[$];
   logic [31:0]       aq[$];
   int                lq[$];
   logic [1:0]        rr_m [256];
   bit                done = 1'b0;
   int                checks = 0;
   int                errors = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor / scoreboard
   initial begin
      fill_t   f;
      commit_t c;
      bit      in_flight = 1'b0;
      int      t0 = 0;
      int      tag_cyc = 0;
      while (!done) begin
         @(negedge clk);
         #1;
         if (done) break;
         if (!rst_n) begin
            check("reset_outputs",
               128'({miss_ready, mem_req, fill_we, tag_we, refill_done, mem_addr,
                     fill_index, fill_way, fill_word, fill_data, tag}),
               128'({1'b1, 100'b0}));
            fq.delete(); cq.delete(); aq.delete(); lq.delete();
            in_flight = 1'b0;
            continue;
         end
         if (mem_req) begin
            if (aq.size() == 0) check("unexpected_req", 128'(1), 128'(0));
            else begin
               check("mem_addr", 128'(mem_addr), 128'(aq[0]));
               if (mem_gnt) void'(aq.pop_front());
            end
         end
         if (fill_we) begin
            if (fq.size() == 0) check("unexpected_fill", 128'(1), 128'(0));
            else begin
               f = fq.pop_front();
               check("fill", 128'({fill_index, fill_way, fill_word, fill_data}), 128'(f));
            end
         end
         if (tag_we || refill_done) begin
            if (cq.size() == 0) check("unexpected_commit", 128'(1), 128'(0));
            else begin
               c = cq.pop_front();
               check("commit", 128'({tag_we, refill_done, tag, fill_index, fill_way}),
                     128'({2'b11, c}));
               check("word15_with_commit", 128'({fill_we, fill_word, fq.size() == 0}),
                     128'({1'b1, 4'hF, 1'b1}));
            end
            tag_cyc = cyc;
         end
         if (in_flight && miss_ready) begin
            if (lq.size() == 0) check("unexpected_ready", 128'(1), 128'(0));
            else check("latency", 128'(cyc - t0), 128'(lq.pop_front()));
            check("ready_after_commit", 128'(cyc - tag_cyc), 128'(1));
            in_flight = 1'b0;
         end
         if (!in_flight && miss_valid && miss_ready) begin
            in_flight = 1'b1;
            t0 = cyc;
         end
      end
      check("drained", 128'(fq.size() + cq.size() + aq.size() + lq.size()), 128'(0));
      check("idle_at_end", 128'({in_flight, miss_ready}), 128'({1'b0, 1'b1}));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // One refill: lookup-stage request followed by the RAM side with random stalls.
   task automatic do_miss(input logic [31:0] a, input int maxg, input int maxr, input bit abort);
      int          gd[16];
      int          rd[16];
      logic [31:0] dat[16];
      logic [31:0] base;
      logic [31:0] r;
      logic [7:0]  idx;
      logic [1:0]  w;
      int          stall = 0;
      int          n = 0;
      for (int b = 0; b < 16; b++) begin
         gd[b]  = int'($urandom_range(maxg, 0));
         rd[b]  = int'($urandom_range(maxr, 0));
         dat[b] = $urandom;
         stall += gd[b] + rd[b];
      end
      base = a & 32'hFFFF_FFC0;
      idx  = a[13:6];
      w    = rr_m[idx];
      while (!miss_ready) begin
         @(negedge clk);
         n++;
         if (n > 200) begin
            $display("FAIL ready_timeout: miss_ready stayed 0 for %0d cycles", n);
            $fatal(1);
         end
      end
      for (int b = 0; b < 16; b++) begin
         fq.push_back(fill_t'{idx, w, 4'(b), dat[b]});
         aq.push_back(base + 32'(4 * b));
      end
      cq.push_back(commit_t'{a[31:14], idx, w});
      lq.push_back(34 + stall);
      miss_valid = 1'b1;
      miss_addr  = a;
      @(negedge clk);
      miss_valid = 1'b0;
      for (int b = 0; b < 16; b++) begin
         for (int i = 0; i < gd[b]; i++) begin
            r          = $urandom;
            mem_gnt    = 1'b0;
            mem_rvalid = r[0];
            mem_rdata  = $urandom;
            miss_valid = r[1];
            miss_addr  = $urandom;
            @(negedge clk);
         end
         r          = $urandom;
         mem_gnt    = 1'b1;
         mem_rvalid = r[0];
         mem_rdata  = $urandom;
         miss_valid = 1'b0;
         @(negedge clk);
         for (int i = 0; i < rd[b]; i++) begin
            r          = $urandom;
            mem_gnt    = r[0];
            mem_rvalid = 1'b0;
            @(negedge clk);
         end
         r          = $urandom;
         mem_gnt    = r[0];
         mem_rvalid = 1'b1;
         mem_rdata  = dat[b];
         @(negedge clk);
         mem_rvalid = 1'b0;
         mem_gnt    = 1'b0;
         if (abort && b == 7) break;
      end
      if (abort) begin
         rst_n      = 1'b0;
         @(negedge clk);
         mem_rvalid = 1'b1;
         mem_rdata  = $urandom;
         @(negedge clk);
         rst_n      = 1'b1;
         @(negedge clk);
         mem_rvalid = 1'b0;
         for (int i = 0; i < 256; i++) rr_m[i] = 2'd0;
      end else begin
         rr_m[idx] = w + 2'd1;
      end
   endtask

   initial begin
      logic [31:0] r;
      rst_n      = 1'b0;
      miss_valid = 1'b0;
      miss_addr  = '0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      for (int i = 0; i < 256; i++) rr_m[i] = 2'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_miss(32'h0000_1A48, 0, 0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         r = $urandom;
         do_miss({r[31:14], 8'h69, r[5:0]}, 0, 0, 1'b0);
      end
      do_miss(32'h0000_1A80, 0, 0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         r = $urandom;
         do_miss({r[31:14], 6'h0, r[7:6], r[5:0]}, 3, 5, 1'b0);
      end
      do_miss(32'h0048_DA44, 1, 2, 1'b1);
      do_miss(32'h0000_1A48, 0, 0, 1'b0);
      do_miss(32'hFFFF_FFC4, 2, 2, 1'b0);
      repeat (3) @(negedge clk);
      done = 1'b1;
   end

endmodule
